// File: rtl/riscv_pkg.sv
// Shared integer-core constants and the writeback request record used by the
// register-file write-side logic.
package riscv_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_req_t;

  // Writes to x0 are architecturally discarded.
  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; depth need not be a power of two.
// Push while full and pop while empty are ignored.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter  int FIFO_DEPTH = 2,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  wb_req_t          din,
  output wb_req_t          dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  wb_req_t          r_mem [FIFO_DEPTH];

  logic w_push;
  logic w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty  = (r_count == '0);
  assign full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is defined
  // solely by the pointers and count, and a reset-free array maps to RAM/LUTRAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// Register-file write-port arbiter: pipeline writeback first, then buffered
// long-latency results, then a direct bypass; plus the pending-write scoreboard.
module reg_write_ctrl
  import riscv_pkg::wb_req_t, riscv_pkg::REG_ADDR_W, riscv_pkg::NUM_REGS, riscv_pkg::is_x0;
#(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_wd,
  input  logic                  mc_issue,
  input  logic [REG_ADDR_W-1:0] mc_issue_rd,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] mc_rd,
  input  logic [XLEN-1:0]       mc_wd,
  input  logic [REG_ADDR_W-1:0] q_a1,
  input  logic [REG_ADDR_W-1:0] q_a2,
  input  logic [REG_ADDR_W-1:0] q_a3,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  busy3,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0]       rf_wd
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_FIFO,
    SRC_BYPASS
  } wr_src_e;

  logic [NUM_REGS-1:1]   r_sb;
  logic [NUM_REGS-1:1]   w_sb_next;
  logic [NUM_REGS-1:0]   w_sb_full;

  wb_req_t               w_push_req;
  wb_req_t               w_head;
  logic                  w_empty;
  logic                  w_full;
  logic [CNT_W-1:0]      w_count;
  logic                  w_push;
  logic                  w_pop;

  wr_src_e               w_src;
  logic                  w_sel_ll;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_wd;
  logic                  w_ll_we;

  assign mc_ready   = !reset && (w_count < CNT_W'(FIFO_DEPTH));
  assign w_push_req = '{rd: mc_rd, wd: mc_wd};

  always_comb begin
    w_src = SRC_NONE;
    if (!reset) begin
      if (pipe_we)                    w_src = SRC_PIPE;
      else if (!w_empty)              w_src = SRC_FIFO;
      else if (mc_valid && mc_ready)  w_src = SRC_BYPASS;
    end
  end

  always_comb begin
    w_sel_rd = '0;
    w_sel_wd = '0;
    w_sel_ll = 1'b0;
    unique case (w_src)
      SRC_PIPE: begin
        w_sel_rd = pipe_rd;
        w_sel_wd = pipe_wd;
      end
      SRC_FIFO: begin
        w_sel_rd = w_head.rd;
        w_sel_wd = w_head.wd;
        w_sel_ll = 1'b1;
      end
      SRC_BYPASS: begin
        w_sel_rd = mc_rd;
        w_sel_wd = mc_wd;
        w_sel_ll = 1'b1;
      end
      default: ;
    endcase
  end

  // A result claimed by the bypass path is written now and never enqueued.
  assign w_pop  = (w_src == SRC_FIFO);
  assign w_push = mc_valid && mc_ready && (w_src != SRC_BYPASS);

  assign rf_we   = (w_src != SRC_NONE) && !is_x0(w_sel_rd);
  assign rf_a3   = w_sel_rd;
  assign rf_wd   = w_sel_wd;
  assign w_ll_we = rf_we && w_sel_ll;

  wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_push_req),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  // NOTE: combinational next-state uses blocking assignments with a default
  // first, so no latch is inferred and the later set overrides an earlier clear.
  always_comb begin
    w_sb_next = r_sb;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (w_ll_we && (w_sel_rd == REG_ADDR_W'(i))) w_sb_next[i] = 1'b0;
      if (mc_issue && (mc_issue_rd == REG_ADDR_W'(i))) w_sb_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_sb <= '0;
    else       r_sb <= w_sb_next;
  end

  assign w_sb_full = {r_sb, 1'b0};

  // A long-latency write on the port this cycle lands before decode reads, so
  // that register is already reported free.
  assign busy1 = !reset && w_sb_full[q_a1] && !(w_ll_we && (rf_a3 == q_a1));
  assign busy2 = !reset && w_sb_full[q_a2] && !(w_ll_we && (rf_a3 == q_a2));
  assign busy3 = !reset && w_sb_full[q_a3] && !(w_ll_we && (rf_a3 == q_a3));

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Directed self-checking bench for reg_write_ctrl: bypass, conflict, full FIFO,
// x0 handling, same-cycle set/clear and reset mid-operation.
module tb_reg_write_ctrl;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            pipe_we;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_wd;
  logic            mc_issue;
  logic [4:0]      mc_issue_rd;
  logic            mc_valid;
  logic            mc_ready;
  logic [4:0]      mc_rd;
  logic [XLEN-1:0] mc_wd;
  logic [4:0]      q_a1;
  logic [4:0]      q_a2;
  logic [4:0]      q_a3;
  logic            busy1;
  logic            busy2;
  logic            busy3;
  logic            rf_we;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd;

  int n_checks = 0;
  int n_fail   = 0;

  reg_write_ctrl #(
    .XLEN       (XLEN),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pipe_we     (pipe_we),
    .pipe_rd     (pipe_rd),
    .pipe_wd     (pipe_wd),
    .mc_issue    (mc_issue),
    .mc_issue_rd (mc_issue_rd),
    .mc_valid    (mc_valid),
    .mc_ready    (mc_ready),
    .mc_rd       (mc_rd),
    .mc_wd       (mc_wd),
    .q_a1        (q_a1),
    .q_a2        (q_a2),
    .q_a3        (q_a3),
    .busy1       (busy1),
    .busy2       (busy2),
    .busy3       (busy3),
    .rf_we       (rf_we),
    .rf_a3       (rf_a3),
    .rf_wd       (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    pipe_we     = 1'b0;
    pipe_rd     = '0;
    pipe_wd     = '0;
    mc_issue    = 1'b0;
    mc_issue_rd = '0;
    mc_valid    = 1'b0;
    mc_rd       = '0;
    mc_wd       = '0;
    q_a1        = '0;
    q_a2        = '0;
    q_a3        = '0;
  endtask

  // Advance to the next negedge and clear the inputs for a fresh cycle.
  task automatic next_cycle();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic expect_write(input string tag, input logic [4:0] rd, input logic [31:0] wd);
    check({tag, "_we"}, 32'(rf_we), 1);
    check({tag, "_a3"}, 32'(rf_a3), 32'(rd));
    check({tag, "_wd"}, rf_wd, wd);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    // Reset: no write, no ready, no busy even with a live pipeline request.
    next_cycle();
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h55; q_a1 = 5'd5;
    #1;
    check("rst_we", 32'(rf_we), 0);
    check("rst_ready", 32'(mc_ready), 0);
    check("rst_busy1", 32'(busy1), 0);

    next_cycle();
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(mc_ready), 1);
    check("post_rst_we", 32'(rf_we), 0);

    // Bypass.
    next_cycle(); mc_issue = 1'b1; mc_issue_rd = 5'd5;
    #1; check("byp_issue_we", 32'(rf_we), 0);
    next_cycle(); q_a1 = 5'd5;
    #1; check("byp_busy_pre", 32'(busy1), 1);
    next_cycle(); mc_valid = 1'b1; mc_rd = 5'd5; mc_wd = 32'hDEADBEEF; q_a1 = 5'd5;
    #1;
    expect_write("byp", 5'd5, 32'hDEADBEEF);
    check("byp_busy_same", 32'(busy1), 0);
    check("byp_ready", 32'(mc_ready), 1);
    next_cycle(); q_a1 = 5'd5;
    #1;
    check("byp_busy_after", 32'(busy1), 0);
    check("byp_after_we", 32'(rf_we), 0);

    // Conflict: pipeline wins, result 7 is queued.
    next_cycle(); mc_issue = 1'b1; mc_issue_rd = 5'd7;
    next_cycle();
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h11;
    mc_valid = 1'b1; mc_rd = 5'd7; mc_wd = 32'h22; q_a3 = 5'd7;
    #1;
    expect_write("cfl_pipe", 5'd3, 32'h11);
    check("cfl_ready", 32'(mc_ready), 1);
    check("cfl_busy3_held", 32'(busy3), 1);
    next_cycle(); q_a3 = 5'd7;
    #1;
    expect_write("cfl_drain", 5'd7, 32'h22);
    check("cfl_busy3_drain", 32'(busy3), 0);
    next_cycle(); q_a3 = 5'd7;
    #1;
    check("cfl_idle_we", 32'(rf_we), 0);
    check("cfl_busy3_after", 32'(busy3), 0);

    // Full FIFO: 8 and 9 accepted under pipeline traffic, 10 stalls.
    next_cycle(); mc_issue = 1'b1; mc_issue_rd = 5'd8;
    next_cycle(); mc_issue = 1'b1; mc_issue_rd = 5'd9;
    next_cycle(); mc_issue = 1'b1; mc_issue_rd = 5'd10;
    next_cycle();
    pipe_we = 1'b1; pipe_rd = 5'd20; pipe_wd = 32'h100;
    mc_valid = 1'b1; mc_rd = 5'd8; mc_wd = 32'h800;
    #1;
    expect_write("full_p0", 5'd20, 32'h100);
    check("full_rdy0", 32'(mc_ready), 1);
    next_cycle();
    pipe_we = 1'b1; pipe_rd = 5'd21; pipe_wd = 32'h101;
    mc_valid = 1'b1; mc_rd = 5'd9; mc_wd = 32'h900;
    #1;
    check("full_p1_a3", 32'(rf_a3), 21);
    check("full_rdy1", 32'(mc_ready), 1);
    next_cycle();
    pipe_we = 1'b1; pipe_rd = 5'd22; pipe_wd = 32'h102;
    mc_valid = 1'b1; mc_rd = 5'd10; mc_wd = 32'hA00; q_a1 = 5'd8;
    #1;
    check("full_p2_a3", 32'(rf_a3), 22);
    check("full_rdy2", 32'(mc_ready), 0);
    check("full_busy8", 32'(busy1), 1);
    next_cycle();
    pipe_we = 1'b1; pipe_rd = 5'd23; pipe_wd = 32'h103;
    mc_valid = 1'b1; mc_rd = 5'd10; mc_wd = 32'hA00;
    #1;
    check("full_p3_a3", 32'(rf_a3), 23);
    check("full_rdy3", 32'(mc_ready), 0);
    next_cycle(); mc_valid = 1'b1; mc_rd = 5'd10; mc_wd = 32'hA00;
    #1;
    expect_write("full_w8", 5'd8, 32'h800);
    check("full_rdy4", 32'(mc_ready), 0);
    next_cycle(); mc_valid = 1'b1; mc_rd = 5'd10; mc_wd = 32'hA00;
    #1;
    expect_write("full_w9", 5'd9, 32'h900);
    check("full_rdy5", 32'(mc_ready), 1);
    next_cycle(); q_a1 = 5'd10;
    #1;
    expect_write("full_w10", 5'd10, 32'hA00);
    check("full_busy10", 32'(busy1), 0);
    next_cycle();
    #1; check("full_idle_we", 32'(rf_we), 0);

    // x0 handling.
    next_cycle();
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wd = 32'h5;
    mc_issue = 1'b1; mc_issue_rd = 5'd0;
    #1; check("x0_pipe_we", 32'(rf_we), 0);
    next_cycle(); mc_valid = 1'b1; mc_rd = 5'd0; mc_wd = 32'h33; q_a1 = 5'd0;
    #1;
    check("x0_byp_we", 32'(rf_we), 0);
    check("x0_busy", 32'(busy1), 0);
    next_cycle();
    pipe_we = 1'b1; pipe_rd = 5'd1; pipe_wd = 32'h1;
    mc_valid = 1'b1; mc_rd = 5'd0; mc_wd = 32'h44;
    mc_issue = 1'b1; mc_issue_rd = 5'd14;
    #1; expect_write("x0_q_pipe", 5'd1, 32'h1);
    next_cycle();
    #1; check("x0_pop_we", 32'(rf_we), 0);
    next_cycle(); mc_valid = 1'b1; mc_rd = 5'd14; mc_wd = 32'h1414;
    #1; expect_write("x0_then_byp", 5'd14, 32'h1414);

    // Same-cycle set and clear of r12: set wins.
    next_cycle(); mc_issue = 1'b1; mc_issue_rd = 5'd12;
    next_cycle();
    mc_valid = 1'b1; mc_rd = 5'd12; mc_wd = 32'h1212;
    mc_issue = 1'b1; mc_issue_rd = 5'd12; q_a1 = 5'd12;
    #1;
    expect_write("sc_w12", 5'd12, 32'h1212);
    check("sc_busy_same", 32'(busy1), 0);
    next_cycle(); q_a1 = 5'd12;
    #1; check("sc_busy_after", 32'(busy1), 1);

    // Reset with two queued results and pending r4/r6/r12.
    next_cycle(); mc_issue = 1'b1; mc_issue_rd = 5'd4;
    next_cycle(); mc_issue = 1'b1; mc_issue_rd = 5'd6;
    next_cycle();
    pipe_we = 1'b1; pipe_rd = 5'd2; pipe_wd = 32'h2;
    mc_valid = 1'b1; mc_rd = 5'd4; mc_wd = 32'h4;
    #1; check("mr_q4_ready", 32'(mc_ready), 1);
    next_cycle();
    pipe_we = 1'b1; pipe_rd = 5'd2; pipe_wd = 32'h2;
    mc_valid = 1'b1; mc_rd = 5'd6; mc_wd = 32'h6;
    q_a1 = 5'd4; q_a2 = 5'd6;
    #1;
    check("mr_q6_ready", 32'(mc_ready), 1);
    check("mr_busy4_pre", 32'(busy1), 1);
    next_cycle(); reset = 1'b1; q_a1 = 5'd4; q_a2 = 5'd6; q_a3 = 5'd12;
    #1;
    check("mr_rst_we", 32'(rf_we), 0);
    check("mr_rst_ready", 32'(mc_ready), 0);
    check("mr_rst_busy1", 32'(busy1), 0);
    check("mr_rst_busy2", 32'(busy2), 0);
    check("mr_rst_busy3", 32'(busy3), 0);
    next_cycle(); reset = 1'b0; q_a1 = 5'd4; q_a2 = 5'd6; q_a3 = 5'd12;
    #1;
    check("mr_post_we", 32'(rf_we), 0);
    check("mr_post_ready", 32'(mc_ready), 1);
    check("mr_post_busy1", 32'(busy1), 0);
    check("mr_post_busy2", 32'(busy2), 0);
    check("mr_post_busy3", 32'(busy3), 0);
    next_cycle();
    #1; check("mr_no_stale", 32'(rf_we), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
